// File: rtl/chunk_add_sequencer_if.sv
// rtl/chunk_add_sequencer_if.sv - operand/result handshake bundle for chunk_add_sequencer
// Carries ovf only when CHUNK_ADD_SEQUENCER_OVF_EN is defined.
interface chunk_add_sequencer_if #(
    parameter int W = 28
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;
`ifdef CHUNK_ADD_SEQUENCER_OVF_EN
    logic         ovf;
`endif

    modport master (
`ifdef CHUNK_ADD_SEQUENCER_OVF_EN
        input  ovf,
`endif
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );

    modport slave (
`ifdef CHUNK_ADD_SEQUENCER_OVF_EN
        output ovf,
`endif
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );
endinterface

// File: rtl/chunk_add_sequencer.sv
// rtl/chunk_add_sequencer.sv - multi-cycle wide adder feeding one chunk per clock through a ripple adder
// Optional signed-overflow output enabled by CHUNK_ADD_SEQUENCER_OVF_EN.
module carry_ripple_adder #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH:0] num1,
    input  logic [WIDTH:0] num2,
    input  logic           c_in,
    output logic [WIDTH:0] sum,
    output logic           c_out
);
    always_comb begin
        logic [WIDTH+1:0] c;
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i <= WIDTH; i++) begin
            sum[i]   = num1[i] ^ num2[i] ^ c[i];
            c[i + 1] = (num1[i] & num2[i]) | (c[i] & (num1[i] ^ num2[i]));
        end
        c_out = c[WIDTH+1];
    end
endmodule

module chunk_add_sequencer #(
    parameter int CHUNK  = 7,
    parameter int NCHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    chunk_add_sequencer_if.slave  bus
);
    localparam int W  = CHUNK * NCHUNK;
    localparam int IW = $clog2(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_r;
    logic            c_out_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
    logic            ovf_r;

    logic [CHUNK-1:0] add_num1;
    logic [CHUNK-1:0] add_num2;
    logic [CHUNK-1:0] add_sum;
    logic             add_c_out;

    assign add_num1 = a_reg[idx*CHUNK +: CHUNK];
    assign add_num2 = b_reg[idx*CHUNK +: CHUNK];

    carry_ripple_adder #(.WIDTH(CHUNK-1)) u_adder (
        .num1  (add_num1),
        .num2  (add_num2),
        .c_in  (carry),
        .sum   (add_sum),
        .c_out (add_c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_r       <= '0;
            c_out_r     <= 1'b0;
            carry       <= 1'b0;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                        sum_r      <= '0;
                        c_out_r    <= 1'b0;
                        ovf_r      <= 1'b0;
                        idx        <= '0;
                        carry      <= bus.c_in;
                        state      <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_r[idx*CHUNK +: CHUNK] <= add_sum;
                    carry                     <= add_c_out;
                    if (idx == LAST) begin
                        // Top chunk's MSB is the final sum sign bit, so overflow is known here.
                        c_out_r     <= add_c_out;
                        ovf_r       <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[CHUNK-1] != a_reg[W-1]);
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
`ifdef CHUNK_ADD_SEQUENCER_OVF_EN
    assign bus.ovf       = ovf_r;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_r;
`endif
endmodule

// File: tb/tb_chunk_add_sequencer.sv
// tb/tb_chunk_add_sequencer.sv - scoreboard bench for chunk_add_sequencer
// Checks ovf too when CHUNK_ADD_SEQUENCER_OVF_EN is defined.
module tb_chunk_add_sequencer;
    localparam int CHUNK  = 7;
    localparam int NCHUNK = 4;
    localparam int W      = CHUNK * NCHUNK;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chunk_add_sequencer_if #(.W(W)) bus();

    chunk_add_sequencer #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t        e;
        logic [63:0] t;
        longint      sa, sb, ss;
        t    = 64'(a) + 64'(b) + 64'(ci);
        e.s  = t[W-1:0];
        e.co = t[W];
        sa   = a[W-1] ? longint'(a) - (longint'(1) <<< W) : longint'(a);
        sb   = b[W-1] ? longint'(b) - (longint'(1) <<< W) : longint'(b);
        ss   = sa + sb + longint'(ci);
        e.ov = (ss > (longint'(1) <<< (W-1)) - 1) || (ss < -(longint'(1) <<< (W-1)));
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got sum 0x%0h with no result expected", bus.sum);
            end else begin
                mon_e = sbq.pop_front();
                check("sum", 64'(bus.sum), 64'(mon_e.s));
                check("c_out", 64'(bus.c_out), 64'(mon_e.co));
`ifdef CHUNK_ADD_SEQUENCER_OVF_EN
                check("ovf", 64'(bus.ovf), 64'(mon_e.ov));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input bit push);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1");
        end
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        if (push) sbq.push_back(model(a, b, ci));
        #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(NCHUNK));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input string name);
        bus.out_ready = 1'b1;
        drive_in(a, b, ci, 1'b1);
        wait_valid(name);
        @(posedge clk); #1;
        check({name, "_pulse_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_busy"}, 64'(bus.busy), 64'd0);
        check({name, "_sum"}, 64'(bus.sum), 64'd0);
        check({name, "_c_out"}, 64'(bus.c_out), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        int           stall;
        bit           seen;
        exp_t         bp;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        do_op(28'h0000001, 28'h0000002, 1'b0, "basic");
        do_op(28'hFFFFFFF, 28'h0000000, 1'b1, "ripple1");
        do_op(28'hFFFFFFF, 28'hFFFFFFF, 1'b1, "ripple2");

        // Backpressure with a competing request held on the input side.
        bus.out_ready = 1'b0;
        drive_in(28'h1111111, 28'h2222222, 1'b0, 1'b1);
        wait_valid("bp");
        bp           = model(28'h1111111, 28'h2222222, 1'b0);
        bus.a        = 28'h0F0F0F0;
        bus.b        = 28'h0707070;
        bus.c_in     = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
            check("bp_sum_held", 64'(bus.sum), 64'(bp.s));
            check("bp_c_out_held", 64'(bus.c_out), 64'(bp.co));
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        sbq.push_back(model(28'h0F0F0F0, 28'h0707070, 1'b1));
        #1;
        bus.in_valid = 1'b0;
        wait_valid("bp_next");
        @(posedge clk); #1;

        // Abort after E2: reset must wipe the operation.
        drive_in(28'hABCDEF1, 28'h5555555, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("abort");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        do_op(28'h1234567, 28'h0ABCDEF, 1'b0, "post_abort");

        do_op(28'h7FFFFFF, 28'h0000001, 1'b0, "ovf_pos");
        do_op(28'h8000000, 28'h8000000, 1'b0, "ovf_neg");

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       ra = '1;
                1:       ra = '0;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       rb = '1;
                1:       rb = W'($urandom_range(0, 3));
                default: rb = W'($urandom);
            endcase
            rc    = 1'($urandom);
            stall = $urandom_range(0, 3);
            if (stall == 0) begin
                do_op(ra, rb, rc, "rand");
            end else begin
                bus.out_ready = 1'b0;
                drive_in(ra, rb, rc, 1'b1);
                wait_valid("rand_stall");
                for (int i = 0; i < stall; i++) begin
                    @(posedge clk); #1;
                    check("rand_stall_held", 64'(bus.out_valid), 64'd1);
                end
                bus.out_ready = 1'b1;
                @(posedge clk); #1;
                check("rand_stall_release", 64'(bus.out_valid), 64'd0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
